// File: rtl/rx_pingpong_ctrl_if.sv
// Bundle between the GMII receiver, the two-bank payload memory and the frame consumer.
// The controller uses the master modport; the environment uses the slave modport.
interface rx_pingpong_ctrl_if #(
    parameter int OCT        = 8,
    parameter int DEPTH_LOG2 = 11
);
    logic                  rx_payload_ipv4;
    logic [OCT-1:0]        rx_payload;
    logic                  rx_irq;
    logic                  buf_we;
    logic [DEPTH_LOG2:0]   buf_waddr;
    logic [OCT-1:0]        buf_wdata;
    logic                  frm_valid;
    logic                  frm_bank;
    logic [DEPTH_LOG2:0]   frm_len;
    logic                  frm_ready;
    logic [15:0]           drop_cnt;

    modport master (
        input  rx_payload_ipv4, rx_payload, rx_irq, frm_ready,
        output buf_we, buf_waddr, buf_wdata, frm_valid, frm_bank, frm_len, drop_cnt
    );

    modport slave (
        output rx_payload_ipv4, rx_payload, rx_irq, frm_ready,
        input  buf_we, buf_waddr, buf_wdata, frm_valid, frm_bank, frm_len, drop_cnt
    );
endinterface

// File: rtl/rx_pingpong_ctrl.sv
// Ping-pong receive buffer controller: writes IPv4 payload into two banks, commits on rx_irq,
// offers frames in arrival order. Drop counter is present only when RX_PP_DROP_CNT_EN is defined.
module rx_pingpong_ctrl #(
    parameter int OCT        = 8,
    parameter int DEPTH_LOG2 = 11,
    parameter int TMO        = 4
) (
    input  logic                 RX_CLK,
    input  logic                 rst,
    rx_pingpong_ctrl_if.master   bus
);
    localparam int AW = DEPTH_LOG2 + 1;
    localparam int TW = $clog2(TMO + 1);
    localparam logic [AW-1:0] CAP      = AW'(2 ** DEPTH_LOG2);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT_IRQ, DROP} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              wbank_q, wbank_d;
    logic              rbank_q, rbank_d;
    logic [1:0]        full_q;
    logic [AW-1:0]     len_q [2];
    logic              buf_we_q, buf_we_d;
    logic [AW-1:0]     buf_waddr_q, buf_waddr_d;
    logic [OCT-1:0]    buf_wdata_q, buf_wdata_d;
    logic              commit;
    logic              rel;
    logic              drop_evt;
    logic              wr_en;
    logic [DEPTH_LOG2-1:0] wr_off;

    assign rel = full_q[rbank_q] && bus.frm_ready;

    // State register
    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_waddr_q <= '0;
            buf_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            buf_we_q    <= buf_we_d;
            buf_waddr_q <= buf_waddr_d;
            buf_wdata_q <= buf_wdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        commit   = 1'b0;
        drop_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rx_payload_ipv4) begin
                    tmo_d = '0;
                    if (!full_q[wbank_q]) begin
                        state_d = WRITE;
                        cnt_d   = AW'(1);
                    end else begin
                        state_d  = DROP;
                        drop_evt = 1'b1;
                    end
                end
            end
            WRITE: begin
                tmo_d = '0;
                if (!bus.rx_payload_ipv4) begin
                    state_d = WAIT_IRQ;
                end else if (cnt_q != CAP) begin
                    cnt_d = cnt_q + AW'(1);
                end else begin
                    state_d  = DROP;
                    drop_evt = 1'b1;
                end
            end
            WAIT_IRQ: begin
                if (bus.rx_irq) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d  = IDLE;
                    drop_evt = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            DROP: begin
                // Leave on end-of-frame, or once the line has been quiet for TMO cycles
                if (bus.rx_irq) begin
                    state_d = IDLE;
                end else if (bus.rx_payload_ipv4) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        wbank_d = commit ? ~wbank_q : wbank_q;
        rbank_d = rel ? ~rbank_q : rbank_q;
    end

    // Output logic: registered write port
    always_comb begin
        wr_en  = 1'b0;
        wr_off = '0;
        case (state_q)
            IDLE:  wr_en = bus.rx_payload_ipv4 && !full_q[wbank_q];
            WRITE: begin
                wr_en  = bus.rx_payload_ipv4 && (cnt_q != CAP);
                wr_off = cnt_q[DEPTH_LOG2-1:0];
            end
            default: wr_en = 1'b0;
        endcase
        buf_we_d    = wr_en;
        buf_waddr_d = wr_en ? {wbank_q, wr_off} : '0;
        buf_wdata_d = wr_en ? bus.rx_payload : '0;
    end

    // Per-bank occupancy; commit and release of different banks may coincide
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic          bank_full_q, bank_full_d;
        logic [AW-1:0] bank_len_q, bank_len_d;

        always_comb begin
            bank_full_d = bank_full_q;
            bank_len_d  = bank_len_q;
            if (rel && (rbank_q == 1'(gi)))
                bank_full_d = 1'b0;
            if (commit && (wbank_q == 1'(gi))) begin
                bank_full_d = 1'b1;
                bank_len_d  = cnt_q;
            end
        end

        always_ff @(posedge RX_CLK) begin
            if (rst) begin
                bank_full_q <= 1'b0;
                bank_len_q  <= '0;
            end else begin
                bank_full_q <= bank_full_d;
                bank_len_q  <= bank_len_d;
            end
        end

        assign full_q[gi] = bank_full_q;
        assign len_q[gi]  = bank_len_q;
    end

    assign bus.buf_we    = buf_we_q;
    assign bus.buf_waddr = buf_waddr_q;
    assign bus.buf_wdata = buf_wdata_q;
    assign bus.frm_valid = full_q[rbank_q];
    assign bus.frm_bank  = rbank_q;
    assign bus.frm_len   = len_q[rbank_q];

`ifdef RX_PP_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge RX_CLK) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign bus.drop_cnt = drop_cnt_q;
`else
    logic drop_evt_unused;
    assign drop_evt_unused = drop_evt;
    assign bus.drop_cnt    = 16'h0000;
`endif
endmodule

// File: tb/tb_rx_pingpong_ctrl.sv
// Directed bench for rx_pingpong_ctrl: frame capture, bank ordering, drops, timeout and reset.
module tb_rx_pingpong_ctrl;
    localparam int OCT        = 8;
    localparam int DEPTH_LOG2 = 11;
    localparam int TMO        = 4;
`ifdef RX_PP_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic RX_CLK = 1'b0;
    logic rst    = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 RX_CLK = ~RX_CLK;

    rx_pingpong_ctrl_if #(.OCT(OCT), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

    rx_pingpong_ctrl #(.OCT(OCT), .DEPTH_LOG2(DEPTH_LOG2), .TMO(TMO)) dut (
        .RX_CLK (RX_CLK),
        .rst    (rst),
        .bus    (bus.master)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_drop(input int n);
        return CNT_EN ? 16'(n) : 16'h0000;
    endfunction

    task automatic tick();
        @(posedge RX_CLK);
        #1;
    endtask

    task automatic chk_frame(input string tag, input logic v, input logic b, input int len);
        chk_eq({tag, "_valid"}, 32'(bus.frm_valid), 32'(v));
        chk_eq({tag, "_bank"},  32'(bus.frm_bank),  32'(b));
        chk_eq({tag, "_len"},   32'(bus.frm_len),   32'(len));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_we"},    32'(bus.buf_we),    32'h0);
        chk_eq({tag, "_waddr"}, 32'(bus.buf_waddr), 32'h0);
        chk_eq({tag, "_wdata"}, 32'(bus.buf_wdata), 32'h0);
        chk_frame(tag, 1'b0, 1'b0, 0);
        chk_eq({tag, "_drop"},  32'(bus.drop_cnt),  32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rx_payload_ipv4 = 1'b0;
        bus.rx_payload      = '0;
        bus.rx_irq          = 1'b0;
        bus.frm_ready       = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("rst");
        rst = 1'b0;
    endtask

    // Drives len payload bytes (base+i); the first nwr must appear as writes into bank.
    task automatic send_bytes(input int len, input int nwr, input logic bank, input logic [7:0] base);
        logic [7:0]  d;
        logic [10:0] off;
        for (int i = 0; i < len; i++) begin
            d   = base + 8'(i);
            off = 11'(i);
            bus.rx_payload_ipv4 = 1'b1;
            bus.rx_payload      = d;
            tick();
            if (i < nwr)
                chk_eq("wr", {11'h0, bus.buf_we, bus.buf_waddr, bus.buf_wdata},
                       {11'h0, 1'b1, bank, off, d});
            else
                chk_eq("nowr", 32'(bus.buf_we), 32'h0);
        end
        bus.rx_payload_ipv4 = 1'b0;
        bus.rx_payload      = '0;
        tick();
        chk_eq("tail_we", 32'(bus.buf_we), 32'h0);
        $display("frame: %0d bytes sent, %0d writes expected to bank %0d", len, nwr, bank);
    endtask

    task automatic irq_pulse();
        bus.rx_irq = 1'b1;
        tick();
        bus.rx_irq = 1'b0;
    endtask

    task automatic ready_pulse();
        bus.frm_ready = 1'b1;
        tick();
        bus.frm_ready = 1'b0;
    endtask

    initial begin
        bus.rx_payload_ipv4 = 1'b0;
        bus.rx_payload      = '0;
        bus.rx_irq          = 1'b0;
        bus.frm_ready       = 1'b0;

        // Single 46-byte frame, then a stray ready and a second frame into bank 1
        do_reset();
        send_bytes(46, 46, 1'b0, 8'h00);
        chk_eq("t1_pre_irq_valid", 32'(bus.frm_valid), 32'h0);
        irq_pulse();
        chk_frame("t1", 1'b1, 1'b0, 46);
        ready_pulse();
        chk_eq("t1_released", 32'(bus.frm_valid), 32'h0);
        ready_pulse();
        chk_eq("t1_stray_ready", 32'(bus.frm_valid), 32'h0);
        send_bytes(20, 20, 1'b1, 8'h80);
        irq_pulse();
        chk_frame("t1b", 1'b1, 1'b1, 20);

        // Three back-to-back 64-byte frames with the consumer stalled
        do_reset();
        send_bytes(64, 64, 1'b0, 8'h10);
        irq_pulse();
        chk_frame("t2_f1", 1'b1, 1'b0, 64);
        send_bytes(64, 64, 1'b1, 8'h50);
        irq_pulse();
        chk_frame("t2_f2_hold", 1'b1, 1'b0, 64);
        send_bytes(64, 0, 1'b0, 8'h90);
        irq_pulse();
        chk_eq("t2_drop", 32'(bus.drop_cnt), 32'(exp_drop(1)));
        chk_frame("t2_still_b0", 1'b1, 1'b0, 64);
        ready_pulse();
        chk_frame("t2_b1", 1'b1, 1'b1, 64);
        ready_pulse();
        chk_eq("t2_empty", 32'(bus.frm_valid), 32'h0);

        // Oversize frame then a normal one into bank 0
        do_reset();
        send_bytes(2049, 2048, 1'b0, 8'h00);
        irq_pulse();
        chk_eq("t3_no_valid", 32'(bus.frm_valid), 32'h0);
        chk_eq("t3_drop", 32'(bus.drop_cnt), 32'(exp_drop(1)));
        send_bytes(60, 60, 1'b0, 8'h11);
        irq_pulse();
        chk_frame("t3_next", 1'b1, 1'b0, 60);

        // Missing end-of-frame interrupt
        do_reset();
        send_bytes(10, 10, 1'b0, 8'h22);
        repeat (TMO + 2) tick();
        chk_eq("t4_no_valid", 32'(bus.frm_valid), 32'h0);
        chk_eq("t4_drop", 32'(bus.drop_cnt), 32'(exp_drop(1)));
        irq_pulse();
        chk_eq("t4_late_irq", 32'(bus.frm_valid), 32'h0);
        send_bytes(5, 5, 1'b0, 8'h33);
        irq_pulse();
        chk_frame("t4_next", 1'b1, 1'b0, 5);

        // Reset at byte 20 while bank 1 holds a frame
        do_reset();
        send_bytes(30, 30, 1'b0, 8'h10);
        irq_pulse();
        send_bytes(30, 30, 1'b1, 8'h20);
        irq_pulse();
        ready_pulse();
        chk_frame("t5_b1_full", 1'b1, 1'b1, 30);
        for (int i = 0; i < 20; i++) begin
            bus.rx_payload_ipv4 = 1'b1;
            bus.rx_payload      = 8'hA0 + 8'(i);
            tick();
        end
        chk_eq("t5_wr19", {11'h0, bus.buf_we, bus.buf_waddr, bus.buf_wdata},
               {11'h0, 1'b1, 1'b0, 11'd19, 8'hB3});
        bus.rx_payload = 8'hB4;
        rst = 1'b1;
        tick();
        chk_reset_outputs("t5_rst");
        rst = 1'b0;
        bus.rx_payload_ipv4 = 1'b0;
        tick();
        chk_eq("t5_after_rst", 32'(bus.frm_valid), 32'h0);
        send_bytes(12, 12, 1'b0, 8'h55);
        irq_pulse();
        chk_frame("t5_next", 1'b1, 1'b0, 12);

        // Release of bank 0 coincides with commit into bank 1
        do_reset();
        send_bytes(16, 16, 1'b0, 8'h01);
        irq_pulse();
        chk_frame("t6_b0", 1'b1, 1'b0, 16);
        send_bytes(24, 24, 1'b1, 8'h02);
        bus.rx_irq    = 1'b1;
        bus.frm_ready = 1'b1;
        tick();
        bus.rx_irq    = 1'b0;
        bus.frm_ready = 1'b0;
        chk_frame("t6_b1", 1'b1, 1'b1, 24);
        chk_eq("t6_full", 32'(dut.full_q), 32'h2);
        ready_pulse();
        chk_eq("t6_empty", 32'(bus.frm_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rx_pingpong_ctrl.md
# rx_pingpong_ctrl

Receive-side buffer controller sitting directly behind the GMII Ethernet receiver on RX_CLK. It captures each IPv4 payload byte stream into one of two memory banks (ping-pong), commits a bank on the receiver's end-of-frame interrupt, and hands completed frames to the next layer in arrival order over a valid/ready handshake. Frames arriving with no free bank, or exceeding bank capacity, are dropped whole.

## Interface
- OCT, 8, byte width
- DEPTH_LOG2, 11, log2 bytes per bank (2048)
- TMO, 4, cycles to wait for end-of-frame interrupt after payload ends
- RX_CLK  in  1  receive clock; every register is clocked on its rising edge
- rst  in  1  synchronous, active-high reset
- rx_payload_ipv4  in  1  byte-valid from the receiver, high for each IPv4 payload byte
- rx_payload  in  OCT  payload byte, aligned with rx_payload_ipv4
- rx_irq  in  1  one-cycle end-of-frame pulse from the receiver
- buf_we  out  1  bank memory write enable
- buf_waddr  out  DEPTH_LOG2+1  {bank, byte offset}
- buf_wdata  out  OCT  write data
- frm_valid  out  1  a committed frame is available
- frm_bank  out  1  bank holding the offered frame
- frm_len  out  DEPTH_LOG2+1  byte count of the offered frame (1..2^DEPTH_LOG2)
- frm_ready  in  1  consumer has finished with the offered frame; releases the bank
- drop_cnt  out  16  dropped-frame counter

## Operation
- Per-bank state: full[1:0], len0, len1. Write bank wbank, read bank rbank; both toggle, giving strict FIFO order.
- FSM states: IDLE, WRITE, WAIT_IRQ, DROP.
- IDLE: on rx_payload_ipv4=1, if full[wbank]=0, write the byte at offset 0, cnt=1, go WRITE; else go DROP.
- WRITE: rx_payload_ipv4=1 and cnt<2^DEPTH_LOG2: write at offset cnt, cnt++. rx_payload_ipv4=1 and cnt=2^DEPTH_LOG2: overflow, go DROP, frame discarded, bank stays free. rx_payload_ipv4=0: go WAIT_IRQ, tmo=0.
- WAIT_IRQ: rx_irq=1: set full[wbank], len[wbank]=cnt, toggle wbank, go IDLE. tmo reaches TMO without rx_irq: discard, go IDLE, count a drop.
- DROP: count a drop on entry; stay until rx_irq=1 or rx_payload_ipv4 has been low for TMO consecutive cycles, then go IDLE. No writes in DROP.
- rx_irq in IDLE: ignored (non-IPv4 or zero-length frame).
- Consumer: frm_valid=full[rbank]; frm_bank=rbank; frm_len=len[rbank]. On frm_valid&&frm_ready: clear full[rbank], toggle rbank. frm_ready with frm_valid=0 is ignored.
- Same cycle commit and release of different banks: both take effect. Bank freed at edge N is allocatable for a frame starting at N+1 or later.
- drop_cnt saturates at 16'hFFFF.

## Timing
- Reset values: buf_we=0, buf_waddr=0, buf_wdata=0, frm_valid=0, frm_bank=0, frm_len=0, drop_cnt=0; wbank=rbank=0, full=0, FSM in IDLE.
- Write latency: byte sampled at edge N appears on buf_we/buf_waddr/buf_wdata after edge N, valid for one cycle.
- Commit latency: rx_irq sampled at edge M → frm_valid high after M if that bank is rbank; otherwise it is offered once the older frame is released.
- frm_valid/frm_bank/frm_len are stable until the handshake; the next frame is offered the cycle after release at the earliest.
- The receiver raises rx_irq one cycle after rx_payload_ipv4 falls; TMO=4 covers this with margin.
- Reset mid-frame: partial frame and both banks discarded, no frm_valid pulse, drop_cnt cleared.

## Configuration
- RX_PP_DROP_CNT_EN defined: drop_cnt implemented as above.
- Not defined: no counter registers; drop_cnt tied to 16'h0000; dropping behaviour otherwise unchanged.

## Test plan
- Single 46-byte IPv4 frame, bytes 0x00..0x2D, rx_irq one cycle after valid falls → 46 writes to addresses 0x000..0x02D, data matching; frm_valid=1, frm_bank=0, frm_len=46.
- Three 64-byte frames back-to-back, frm_ready held low → frames 1 and 2 in banks 0 and 1, frame 3 dropped, drop_cnt=1; then frm_ready pulses → frm_len=64 for bank 0, then bank 1, in order.
- 2049-byte frame → 2048 writes, no frm_valid, drop_cnt=1; the following 60-byte frame lands in bank 0 with frm_len=60.
- Payload ends with no rx_irq → after TMO cycles return to IDLE, no frm_valid, drop_cnt=1.
- rst asserted at byte 20 of a frame with bank 1 full → all outputs return to reset values next cycle; the next frame is written to bank 0.
- Release of bank 0 and commit into bank 1 in the same cycle → bank 1 offered next cycle, full=2'b10.
